// File: rtl/hilo_pkg.sv
// Shared op codes, FSM state encoding and sizing helper for the HI/LO multiply/divide unit.
package hilo_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_DIV   = 3'd4,
    OP_DIVU  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL     = 2'd1,
    ST_DIV_RUN = 2'd2,
    ST_DIV_FIX = 2'd3
  } state_e;

  // Ceiling log2, used to size the divider iteration counter
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned      r;
    longint unsigned  v;
    r = 0;
    v = 64'd1;
    while (v < 64'(n)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hilo_divider.sv
// Iterative restoring divider core on unsigned magnitudes; one quotient bit per step.
module hilo_divider
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] divisor_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] sub;
  logic             fits;

  // Partial remainder shifted left with the next dividend bit; quotient register doubles as dividend
  always_comb begin
    shifted = {remainder, quotient[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor_q});
    sub     = shifted[WIDTH-1:0] - divisor_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      divisor_q <= '0;
      count     <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      divisor_q <= divisor;
      count     <= CNT_W'(WIDTH);
    end else if (step && (count != '0)) begin
      remainder <= fits ? sub : shifted[WIDTH-1:0];
      quotient  <= {quotient[WIDTH-2:0], fits};
      count     <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO unit: owns HI and LO, runs single-cycle mul/madd/msub, iterative div and MTHI/MTLO.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] DIV_ZERO_LO = '1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = clog2(WIDTH + 1);

  state_e           state, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_d, lo_d;
  logic             busy_d, done_d;
  logic             div_load, div_step, is_signed_div, q_neg, r_neg;
  logic [WIDTH-1:0] div_dividend, div_divisor, div_quo, div_rem;
  logic [WIDTH-1:0] quo_fixed, rem_fixed;
  logic [CNT_W-1:0] div_count;
  logic [ACC_W-1:0] mul_a, mul_b, prod;

  // Divider is loaded with operand magnitudes taken directly from the request
  always_comb begin
    is_signed_div = (op_e'(Op) == OP_DIV);
    div_dividend  = (is_signed_div && A[WIDTH-1]) ? (WIDTH'(0) - A) : A;
    div_divisor   = (is_signed_div && B[WIDTH-1]) ? (WIDTH'(0) - B) : B;
  end

  // Low 2*WIDTH bits of the extended product equal the signed product
  always_comb begin
    if (op_q == OP_MULTU) begin
      mul_a = {{WIDTH{1'b0}}, a_q};
      mul_b = {{WIDTH{1'b0}}, b_q};
    end else begin
      mul_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      mul_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end
    prod = mul_a * mul_b;
  end

  always_comb begin
    q_neg     = (op_q == OP_DIV) && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    r_neg     = (op_q == OP_DIV) && a_q[WIDTH-1];
    quo_fixed = q_neg ? (WIDTH'(0) - div_quo) : div_quo;
    rem_fixed = r_neg ? (WIDTH'(0) - div_rem) : div_rem;
    if (b_q == '0) begin
      quo_fixed = DIV_ZERO_LO;
      rem_fixed = a_q;
    end
  end

  hilo_divider #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_divider (
    .clk       (Clk),
    .reset     (Reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_quo),
    .remainder (div_rem),
    .count     (div_count)
  );

  always_comb begin
    state_d  = state;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = Hi;
    lo_d     = Lo;
    done_d   = 1'b0;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          op_d = op_e'(Op);
          a_d  = A;
          b_d  = B;
          case (op_e'(Op))
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: state_d = ST_MUL;
            OP_DIV, OP_DIVU: begin
              state_d  = ST_DIV_RUN;
              div_load = 1'b1;
            end
            OP_MTHI: begin
              hi_d   = A;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = A;
              done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_MUL: begin
        case (op_q)
          OP_MADD: {hi_d, lo_d} = {Hi, Lo} + prod;
          OP_MSUB: {hi_d, lo_d} = {Hi, Lo} - prod;
          default: {hi_d, lo_d} = prod;
        endcase
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_DIV_RUN: begin
        div_step = 1'b1;
        if (div_count == CNT_W'(1)) state_d = ST_DIV_FIX;
      end
      ST_DIV_FIX: begin
        lo_d    = quo_fixed;
        hi_d    = rem_fixed;
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      op_q  <= OP_MULT;
      a_q   <= '0;
      b_q   <= '0;
      Hi    <= '0;
      Lo    <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= state_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      Hi    <= hi_d;
      Lo    <= lo_d;
      Busy  <= busy_d;
      Done  <= done_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: per-op expected HI:LO, latency and Busy behaviour.
module tb_hilo_muldiv_unit;

  logic        Clk, Reset, Start;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] hilo;
    int          lat;
    logic        busy;
  } exp_t;

  exp_t        scoreboard[$];
  logic [31:0] mhi, mlo;
  string       op_name[8] = '{"MULT", "MULTU", "MADD", "MSUB", "DIV", "DIVU", "MTHI", "MTLO"};

  hilo_muldiv_unit #(.WIDTH(32), .DIV_ZERO_LO(32'hFFFFFFFF)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b, hi, lo);
    longint sa, sbv, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (op)
      3'd0: res = 64'(sa * sbv);
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: res = {hi, lo} + 64'(sa * sbv);
      3'd3: res = {hi, lo} - 64'(sa * sbv);
      3'd4: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd5: res = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd6: res = {a, lo};
      default: res = {hi, a};
    endcase
    return res;
  endfunction

  // Push the expectation, issue one op, and wait (bounded) for Done; optionally pulse a stray Start
  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input int inject,
                       output int lat, output logic bf, output logic bd);
    logic [63:0] e;
    e = model(op, a, b, mhi, mlo);
    {mhi, mlo} = e;
    scoreboard.push_back('{hilo: e, lat: (op < 3'd4) ? 2 : (op < 3'd6) ? 34 : 1, busy: (op < 3'd6)});
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    lat = 1;
    bf  = Busy;
    while (!Done && lat < 100) begin
      if (lat == inject) begin
        Start = 1'b1; Op = 3'd6; A = 32'hDEADBEEF;
      end
      @(posedge Clk); #1;
      Start = 1'b0;
      lat++;
    end
    bd = Busy;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Op = 3'd0; A = '0; B = '0;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b0;
    mhi = '0; mlo = '0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", Hi); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", Lo); end
  endtask

  // Runs a table of ops; plan entries with plan_en set are also compared to literal values
  task automatic run_table(input string tag, input logic [2:0] ops[], input logic [31:0] as[],
                           input logic [31:0] bs[], input int injects[], input logic [63:0] plan[],
                           input logic plan_en[]);
    int lat;
    logic bf, bd;
    exp_t ex;
    foreach (ops[i]) begin
      issue(ops[i], as[i], bs[i], injects[i], lat, bf, bd);
      ex = scoreboard.pop_front();
      checks++;
      if (lat != ex.lat) begin
        errors++; $display("FAIL %s_%0d_%s latency got %0d want %0d", tag, i, op_name[ops[i]], lat, ex.lat);
      end
      checks++;
      if ({Hi, Lo} !== ex.hilo) begin
        errors++; $display("FAIL %s_%0d_%s hilo got %h want %h", tag, i, op_name[ops[i]], {Hi, Lo}, ex.hilo);
      end
      checks++;
      if (bf !== ex.busy || bd !== 1'b0) begin
        errors++; $display("FAIL %s_%0d_%s busy got %b/%b want %b/0", tag, i, op_name[ops[i]], bf, bd, ex.busy);
      end
      if (plan_en[i]) begin
        checks++;
        if ({Hi, Lo} !== plan[i]) begin
          errors++; $display("FAIL %s_%0d_%s plan got %h want %h", tag, i, op_name[ops[i]], {Hi, Lo}, plan[i]);
        end
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    run_table("mtx", '{3'd6, 3'd7}, '{32'h12345678, 32'h9ABCDEF0}, '{32'd0, 32'd0}, '{0, 0},
              '{64'h12345678_00000000, 64'h12345678_9ABCDEF0}, '{1'b1, 1'b1});
  endtask

  task automatic test_mul();
    run_table("mul", '{3'd0, 3'd1}, '{32'hFFFFFFFF, 32'hFFFFFFFF}, '{32'd2, 32'd2}, '{0, 0},
              '{64'hFFFFFFFF_FFFFFFFE, 64'h00000001_FFFFFFFE}, '{1'b1, 1'b1});
  endtask

  task automatic test_madd_msub();
    run_table("acc", '{3'd6, 3'd7, 3'd2, 3'd3}, '{32'd0, 32'hFFFFFFFF, 32'd1, 32'd1},
              '{32'd0, 32'd0, 32'd1, 32'd2}, '{0, 0, 0, 0},
              '{64'd0, 64'h00000000_FFFFFFFF, 64'h00000001_00000000, 64'h00000000_FFFFFFFE},
              '{1'b0, 1'b1, 1'b1, 1'b1});
  endtask

  task automatic test_div();
    run_table("div", '{3'd4, 3'd5, 3'd4}, '{32'hFFFFFFF9, 32'd100, 32'h80000000},
              '{32'd2, 32'd0, 32'hFFFFFFFF}, '{5, 0, 0},
              '{64'hFFFFFFFF_FFFFFFFD, 64'h00000064_FFFFFFFF, 64'h00000000_80000000},
              '{1'b1, 1'b1, 1'b1});
  endtask

  task automatic test_back_to_back();
    run_table("b2b", '{3'd0, 3'd2, 3'd7, 3'd5, 3'd3}, '{32'd7, 32'h00010000, 32'd55, 32'd1000, 32'hFFFFFFFF},
              '{32'hFFFFFFFD, 32'h00010000, 32'd0, 32'd7, 32'hFFFFFFFF}, '{0, 0, 0, 0, 0},
              '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0}, '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    @(posedge Clk); #1;
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", Done); end
  endtask

  task automatic test_random();
    logic [2:0]  ops[];
    logic [31:0] as[], bs[];
    int          inj[];
    logic [63:0] plan[];
    logic        pen[];
    ops = new[12]; as = new[12]; bs = new[12]; inj = new[12]; plan = new[12]; pen = new[12];
    foreach (ops[i]) begin
      ops[i]  = 3'($urandom_range(0, 7));
      as[i]   = $urandom;
      bs[i]   = (i % 3 == 0) ? 32'($urandom_range(0, 9)) - 32'd4 : $urandom;
      inj[i]  = (i % 4 == 1) ? 1 : 0;
      plan[i] = 64'd0;
      pen[i]  = 1'b0;
    end
    run_table("rnd", ops, as, bs, inj, plan, pen);
  endtask

  task automatic test_reset_mid_div();
    Start = 1'b1; Op = 3'd4; A = 32'hFFFFFFF9; B = 32'd2;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (9) begin @(posedge Clk); #1; end
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL mid_div_busy got %b want 1", Busy); end
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    mhi = '0; mlo = '0;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Hi !== 32'd0 || Lo !== 32'd0) begin
      errors++; $display("FAIL abort_state got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", Busy, Done, Hi, Lo);
    end
    run_table("post", '{3'd0}, '{32'd3}, '{32'd5}, '{0}, '{64'h00000000_0000000F}, '{1'b1});
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_mul();
    test_madd_msub();
    test_div();
    test_back_to_back();
    test_random();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Parametrised sequential HI/LO unit for the EX stage; the next generation of the HI/LO add/sub datapath.
- Owns the HI and LO registers and executes MULT/MULTU, MADD/MSUB (64-bit accumulate into HI:LO), DIV/DIVU (iterative), and MTHI/MTLO.
- Exposes Busy so the hazard unit can stall mfhi/mflo and any new HI/LO op until the result is written.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, the accumulator is 2*WIDTH.
- DIV_ZERO_LO, all ones, value written to LO on divide by zero.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  3  0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 DIV, 5 DIVU, 6 MTHI, 7 MTLO.
- A  input  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO data).
- B  input  WIDTH  rt operand (multiplier / divisor).
- Busy  output  1  operation in flight; Start is ignored while high.
- Done  output  1  one-cycle pulse; HI/LO hold the new values in this cycle.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, divider cleared. Reset mid-operation aborts it; no partial write.
- States: IDLE, MUL, DIV_RUN, DIV_FIX.
- IDLE:
  - Start=1 latches Op, A and B at edge E0.
  - Ops 0-3 go to MUL.
  - Ops 4-5 go to DIV_RUN with the iteration counter set to WIDTH.
  - Op 6 writes Hi=A at E0; Op 7 writes Lo=A at E0. Both stay in IDLE and pulse Done in the cycle after E0; Busy never rises.
- MUL (one cycle):
  - P = A*B, signed for ops 0/2/3, unsigned for op 1, full 2*WIDTH bits.
  - At E1: op 0/1 write {Hi,Lo}=P; op 2 writes {Hi,Lo}+=P; op 3 writes {Hi,Lo}-=P.
  - Accumulate is modulo 2^(2*WIDTH); wrap is silent.
  - Return to IDLE; Done=1 in the cycle after E1.
- DIV_RUN:
  - Restoring shift-subtract on magnitudes; signed magnitudes for op 4, raw values for op 5.
  - One quotient bit per cycle for WIDTH cycles (E1..E_WIDTH), then DIV_FIX.
- DIV_FIX (one cycle, edge E_WIDTH+1):
  - Signed: quotient is negated if the operand signs differ (truncates toward zero); remainder takes the sign of the dividend.
  - Writes Lo=quotient, Hi=remainder; return to IDLE; Done=1 in the following cycle.
- Divide by zero (B=0): runs full latency, then Lo=DIV_ZERO_LO, Hi=A. No exception.
- Signed overflow (A=most-negative, B=-1): Lo=most-negative, Hi=0.
- Busy is high from the cycle after E0 through the cycle of the HI/LO write edge inclusive. It is low in the Done cycle.
- Start asserted in the Done cycle is accepted (back-to-back issue).
- Start while Busy is ignored: no queueing and no error.
- Hi/Lo hold their old values until the write edge. There are no intermediate values on the outputs.
- Latency from Start edge to Done cycle: MTHI/MTLO 1, mul-class 2, div-class WIDTH+2.

Decomposition:
- hilo_pkg holds:
  - Op codes: OP_MULT..OP_MTLO.
  - State encoding: ST_IDLE, ST_MUL, ST_DIV_RUN, ST_DIV_FIX.
  - Counter width function clog2(WIDTH+1).
- Sub-module hilo_divider:
  - Iterative unsigned core with load/step/count and quotient/remainder outputs.
  - Sign handling, the FSM and the multiplier stay in hilo_muldiv_unit.

Test Plan:
- Reset, then MTHI A=0x12345678 and MTLO A=0x9ABCDEF0 -> Done 1 cycle after each; Hi=0x12345678, Lo=0x9ABCDEF0; Busy stays 0.
- MULT A=0xFFFFFFFF(-1), B=2 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFE. MULTU with the same operands -> Hi=0x00000001, Lo=0xFFFFFFFE. Done 2 cycles after Start.
- Hi:Lo=0x00000000_FFFFFFFF, MADD A=1, B=1 -> Hi=1, Lo=0. Then MSUB A=1, B=2 -> Hi=0, Lo=0xFFFFFFFE.
- DIV A=-7, B=2 -> Lo=-3 (0xFFFFFFFD), Hi=-1; Done exactly 34 cycles after the Start edge. A Start pulsed mid-divide is ignored and the result is unchanged.
- DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=100. DIV A=0x80000000, B=-1 -> Lo=0x80000000, Hi=0.
- Reset asserted at iteration 10 of a DIV -> next cycle Busy=0, Done=0, Hi=Lo=0. A fresh MULT 3*5 issued immediately after -> Lo=15, Hi=0.
